// File: rtl/conv_pkg.sv
// Shared types for the conv/pool datapath: memory selects, widths, pixel type.
package conv_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 20;

  // Signed 4.16 fixed-point pixel.
  typedef logic signed [DATA_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    MEM_NONE   = 3'b000,
    MEM_LAYER0 = 3'b001,
    MEM_LAYER1 = 3'b011
  } mem_sel_e;

  function automatic logic sel_is_legal(input logic [2:0] s);
    return (s == MEM_LAYER0) || (s == MEM_LAYER1);
  endfunction

endpackage

// File: rtl/layer_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;

  // Pass one covers ptr..N-1; pass two only reaches 0..ptr-1 when pass one found nothing.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing the single layer-memory port;
// registers the winning command and returns read data to the issuer.
module layer_mem_arbiter
  import conv_pkg::*;
#(
  parameter  int NREQ   = 3,
  parameter  int ADDR_W = conv_pkg::ADDR_W,
  parameter  int DATA_W = conv_pkg::DATA_W,
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ-1:0]        lock,
  input  logic [3*NREQ-1:0]      sel,
  input  logic [ADDR_W*NREQ-1:0] addr,
  input  logic [DATA_W*NREQ-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   sel_err,
  output logic                   cwr,
  output logic                   crd,
  output logic [ADDR_W-1:0]      caddr_wr,
  output logic [ADDR_W-1:0]      caddr_rd,
  output logic [DATA_W-1:0]      cdata_wr,
  input  logic [DATA_W-1:0]      cdata_rd,
  output logic [2:0]             csel,
  output logic [IDX_W-1:0]       dbg_rr_ptr,
  output logic                   dbg_owner_vld,
  output logic [IDX_W-1:0]       dbg_owner
);

  // Handshake: requester i raises req[i] with payload held stable; the transfer
  // happens in the cycle where req[i] & gnt[i]. gnt is combinational, at most
  // one-hot, never set without req. A new payload may follow the next cycle.

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              owner_vld_q, owner_vld_d;

  logic [NREQ-1:0]   rr_gnt, owner_oh, gnt_raw;
  logic              owner_active, xfer;

  logic [IDX_W-1:0]  win_idx;
  logic              win_we, win_lock;
  logic [2:0]        win_sel;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              cwr_q, crd_q, sel_err_q;
  logic [2:0]        csel_q;
  logic [ADDR_W-1:0] caddr_wr_q, caddr_rd_q;
  logic [DATA_W-1:0] cdata_wr_q;
  logic [IDX_W-1:0]  rd_idx_q, rtag_q;
  logic              rtag_vld_q;

  rr_pick #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt)
  );

  // An owner whose req has dropped loses the port this very cycle.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_oh[i] = owner_vld_q && (owner_q == IDX_W'(i));
    end
    owner_active = |(owner_oh & req);
    gnt_raw      = owner_active ? owner_oh : rr_gnt;
    gnt          = reset ? gnt_raw : '0;
    xfer         = |gnt;
  end

  always_comb begin
    win_idx   = '0;
    win_we    = 1'b0;
    win_lock  = 1'b0;
    win_sel   = 3'b000;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_idx   = IDX_W'(i);
        win_we    = we[i];
        win_lock  = lock[i];
        win_sel   = sel[i*3 +: 3];
        win_addr  = addr[i*ADDR_W +: ADDR_W];
        win_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    if (xfer) begin
      rr_ptr_d    = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
      owner_d     = win_idx;
      owner_vld_d = win_lock;
    end else if (owner_vld_q) begin
      owner_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
    end
  end

  // Addresses and write data hold between transfers; only strobes and csel idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      csel_q     <= MEM_NONE;
      caddr_wr_q <= '0;
      caddr_rd_q <= '0;
      cdata_wr_q <= '0;
      rd_idx_q   <= '0;
      rtag_q     <= '0;
      rtag_vld_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      cwr_q      <= xfer && win_we;
      crd_q      <= xfer && !win_we;
      csel_q     <= xfer ? win_sel : MEM_NONE;
      if (xfer && win_we) begin
        caddr_wr_q <= win_addr;
        cdata_wr_q <= win_wdata;
      end
      if (xfer && !win_we) begin
        caddr_rd_q <= win_addr;
        rd_idx_q   <= win_idx;
      end
      rtag_vld_q <= crd_q;
      rtag_q     <= rd_idx_q;
      if (xfer && !sel_is_legal(win_sel)) begin
        sel_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rvalid[i] = rtag_vld_q && (rtag_q == IDX_W'(i));
    end
  end

  assign rdata         = cdata_rd;
  assign sel_err       = sel_err_q;
  assign cwr           = cwr_q;
  assign crd           = crd_q;
  assign csel          = csel_q;
  assign caddr_wr      = caddr_wr_q;
  assign caddr_rd      = caddr_rd_q;
  assign cdata_wr      = cdata_wr_q;
  assign dbg_rr_ptr    = rr_ptr_q;
  assign dbg_owner_vld = owner_vld_q;
  assign dbg_owner     = owner_q;

endmodule
